quantizer_sequencer: RTL and testbench

Sequences one 8x8 block (64 signed 16-bit DCT coefficients) through the shared pipelined_divider to quantize it. Holds a writable 64-entry quantization table. Issues one coefficient per cycle with a tag, then writes each returned quotient to the output buffer at the address carried in the tag. Sits between the DCT coefficient buffer and the zigzag/entropy stage.

---
 rtl/quantizer_sequencer_pkg.sv | 27 ++
 rtl/quantizer_sequencer_if.sv | 34 +++
 rtl/quantizer_sequencer_quant_table.sv | 31 +++
 rtl/quantizer_sequencer.sv | 140 ++++++++++++++
 tb/tb_quantizer_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/quantizer_sequencer_pkg.sv
// Shared constants, tag layout and FSM encoding for the quantizer sequencer.
// The tag sent with each coefficient is {valid, epoch, index}.
package quantizer_sequencer_pkg;

  localparam int unsigned NUM_COEFS              = 64;
  localparam int unsigned COEF_IDX_W             = 6;
  localparam int unsigned COEF_W                 = 16;
  localparam int unsigned QT_W                   = 8;
  localparam int unsigned TAG_W                  = 8;
  localparam int unsigned TAG_VALID_BIT          = 7;
  localparam int unsigned TAG_EPOCH_BIT          = 6;
  localparam int unsigned RES_CNT_W              = COEF_IDX_W + 1;
  localparam int unsigned DIVIDER_PIPELINE_DEPTH = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } seq_state_e;

  function automatic logic [TAG_W-1:0] make_tag(input logic epoch,
                                                input logic [COEF_IDX_W-1:0] idx);
    return {1'b1, epoch, idx};
  endfunction

endpackage

// File: rtl/quantizer_sequencer_if.sv
// Request/response bundle between the quantizer sequencer and the shared pipelined divider.
// The sequencer is the master; the divider is the slave.
interface quantizer_sequencer_if;
  import quantizer_sequencer_pkg::*;

  logic signed [COEF_W-1:0] div_dividend;
  logic        [QT_W-1:0]   div_divisor;
  logic        [TAG_W-1:0]  div_tag;
  logic                     div_input_valid;
  logic signed [COEF_W-1:0] div_quotient;
  logic        [TAG_W-1:0]  div_tag_out;
  logic                     div_output_valid;

  modport master (
    output div_dividend,
    output div_divisor,
    output div_tag,
    output div_input_valid,
    input  div_quotient,
    input  div_tag_out,
    input  div_output_valid
  );

  modport slave (
    input  div_dividend,
    input  div_divisor,
    input  div_tag,
    input  div_input_valid,
    output div_quotient,
    output div_tag_out,
    output div_output_valid
  );

endinterface

// File: rtl/quantizer_sequencer_quant_table.sv
// 64-entry quantization table: writes only while allowed, a written zero becomes one,
// read is combinational so the divisor lines up with the registered issue index.
module quantizer_sequencer_quant_table
  import quantizer_sequencer_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_allow,
  input  logic                  wr_en,
  input  logic [COEF_IDX_W-1:0] wr_addr,
  input  logic [QT_W-1:0]       wr_data,
  input  logic [COEF_IDX_W-1:0] rd_addr,
  output logic [QT_W-1:0]       rd_data
);

  logic [QT_W-1:0] entry_q [NUM_COEFS];

  // Divider must never see a zero divisor.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_COEFS); i++) begin
        entry_q[i] <= QT_W'(1);
      end
    end else if (wr_en && wr_allow) begin
      entry_q[wr_addr] <= (wr_data == '0) ? QT_W'(1) : wr_data;
    end
  end

  assign rd_data = entry_q[rd_addr];

endmodule

// File: rtl/quantizer_sequencer.sv
// Streams one 8x8 coefficient block through the shared divider, one per cycle, and writes
// each returned quotient back by the index carried in its tag.
module quantizer_sequencer
  import quantizer_sequencer_pkg::*;
(
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  input  logic                         qt_wr_en,
  input  logic        [COEF_IDX_W-1:0] qt_wr_addr,
  input  logic        [QT_W-1:0]       qt_wr_data,
  output logic        [COEF_IDX_W-1:0] coef_rd_addr,
  input  logic signed [COEF_W-1:0]     coef_rd_data,
  quantizer_sequencer_if.master        div_if,
  output logic                         out_wr_en,
  output logic        [COEF_IDX_W-1:0] out_wr_addr,
  output logic signed [COEF_W-1:0]     out_wr_data
);

  seq_state_e state_q, state_d;
  logic                     epoch_q, epoch_d;
  logic [COEF_IDX_W-1:0]    issue_cnt_q, issue_cnt_d;
  logic [RES_CNT_W-1:0]     res_cnt_q, res_cnt_d;
  logic                     iss_vld_q;
  logic [COEF_IDX_W-1:0]    iss_idx_q;
  logic                     wr_en_q;
  logic [COEF_IDX_W-1:0]    wr_addr_q;
  logic signed [COEF_W-1:0] wr_data_q;
  logic                     active;
  logic                     accept;
  logic [QT_W-1:0]          qt_rd_data;

  assign active = (state_q == StIssue) || (state_q == StDrain);

  // The tag check also drops garbage from a divider whose valid bits are not reset.
  assign accept = div_if.div_output_valid &&
                  div_if.div_tag_out[TAG_VALID_BIT] &&
                  (div_if.div_tag_out[TAG_EPOCH_BIT] == epoch_q) &&
                  active;

  always_comb begin
    state_d     = state_q;
    epoch_d     = epoch_q;
    issue_cnt_d = issue_cnt_q;
    res_cnt_d   = res_cnt_q + RES_CNT_W'(accept);
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StIssue;
          epoch_d     = ~epoch_q;
          issue_cnt_d = '0;
          res_cnt_d   = '0;
        end
      end
      StIssue: begin
        issue_cnt_d = issue_cnt_q + COEF_IDX_W'(1);
        if (issue_cnt_q == COEF_IDX_W'(NUM_COEFS - 1)) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (res_cnt_q == RES_CNT_W'(NUM_COEFS)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      epoch_q     <= 1'b0;
      issue_cnt_q <= '0;
      res_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      epoch_q     <= epoch_d;
      issue_cnt_q <= issue_cnt_d;
      res_cnt_q   <= res_cnt_d;
    end
  end

  // Issue stage trails the read address by one cycle to line up with coef_rd_data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      iss_vld_q <= 1'b0;
      iss_idx_q <= '0;
    end else begin
      iss_vld_q <= (state_q == StIssue);
      iss_idx_q <= issue_cnt_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= accept;
      if (accept) begin
        wr_addr_q <= div_if.div_tag_out[COEF_IDX_W-1:0];
        wr_data_q <= div_if.div_quotient;
      end
    end
  end

  quantizer_sequencer_quant_table u_quant_table (
    .clock    (clock),
    .reset    (reset),
    .wr_allow (state_q == StIdle),
    .wr_en    (qt_wr_en),
    .wr_addr  (qt_wr_addr),
    .wr_data  (qt_wr_data),
    .rd_addr  (iss_idx_q),
    .rd_data  (qt_rd_data)
  );

  assign busy         = active;
  assign done         = (state_q == StDone);
  assign coef_rd_addr = issue_cnt_q;

  assign div_if.div_input_valid = iss_vld_q;
  assign div_if.div_dividend    = coef_rd_data;
  assign div_if.div_divisor     = qt_rd_data;
  assign div_if.div_tag         = make_tag(epoch_q, iss_idx_q);

  assign out_wr_en   = wr_en_q;
  assign out_wr_addr = wr_addr_q;
  assign out_wr_data = wr_data_q;

endmodule

// File: tb/tb_quantizer_sequencer.sv
// Bench for quantizer_sequencer: behavioural divider, coefficient memory and
// quantization model; each scenario task checks its own results.
module tb_quantizer_sequencer;
  import quantizer_sequencer_pkg::*;

  localparam int D     = int'(DIVIDER_PIPELINE_DEPTH);
  localparam int SLOTS = 256;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic busy, done;
  logic qt_wr_en = 1'b0;
  logic [5:0] qt_wr_addr = '0;
  logic [7:0] qt_wr_data = '0;
  logic [5:0] coef_rd_addr;
  logic signed [15:0] coef_rd_data;
  logic out_wr_en;
  logic [5:0] out_wr_addr;
  logic signed [15:0] out_wr_data;

  quantizer_sequencer_if dif ();

  quantizer_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .qt_wr_en     (qt_wr_en),
    .qt_wr_addr   (qt_wr_addr),
    .qt_wr_data   (qt_wr_data),
    .coef_rd_addr (coef_rd_addr),
    .coef_rd_data (coef_rd_data),
    .div_if       (dif.master),
    .out_wr_en    (out_wr_en),
    .out_wr_addr  (out_wr_addr),
    .out_wr_data  (out_wr_data)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  logic signed [15:0] coef_mem [64];
  int  tbl_model [64];
  int  exp_q [64];
  logic exp_epoch = 1'b0;

  always @(posedge clock) coef_rd_data <= coef_mem[coef_rd_addr];

  // Divider model: quotient = truncating signed division, returned D cycles later
  // (or later and out of order when perm_mode is set).
  bit   slot_v [SLOTS];
  logic signed [15:0] slot_q [SLOTS];
  logic [7:0] slot_t [SLOTS];
  int ncyc = 0;
  bit perm_mode = 1'b0;
  int inject_mode = 0;

  always @(negedge clock) begin
    int s;
    int dly;
    logic [31:0] r;
    if (dif.div_input_valid === 1'b1) begin
      dly = perm_mode ? D + int'($urandom_range(0, 12)) : D;
      s = (ncyc + dly) % SLOTS;
      while (slot_v[s]) s = (s + 1) % SLOTS;
      slot_v[s] = 1'b1;
      if (dif.div_divisor == 8'd0) slot_q[s] = 16'sh7fff;
      else slot_q[s] = 16'(int'(dif.div_dividend) / int'(dif.div_divisor));
      slot_t[s] = dif.div_tag;
    end
    s = ncyc % SLOTS;
    r = $urandom;
    if (slot_v[s]) begin
      dif.div_output_valid = 1'b1;
      dif.div_quotient     = slot_q[s];
      dif.div_tag_out      = slot_t[s];
      slot_v[s]            = 1'b0;
    end else if (inject_mode != 0 && r[9]) begin
      dif.div_output_valid = 1'b1;
      dif.div_quotient     = 16'($urandom);
      if (inject_mode == 2) dif.div_tag_out = r[7:0];
      else if (r[8]) dif.div_tag_out = {1'b1, ~exp_epoch, r[5:0]};
      else dif.div_tag_out = {1'b0, r[6:0]};
    end else begin
      dif.div_output_valid = 1'b0;
      dif.div_quotient     = 16'($urandom);
      dif.div_tag_out      = r[7:0];
    end
    ncyc++;
  end

  // Per-block observations, filled by run_block.
  int r_done_rel, r_done_cnt, r_wr_cnt, r_bad_wr, r_fv, r_lv, r_vcnt;
  int r_fw, r_lw, r_bf, r_bl, r_bcnt, r_tag_err;
  logic r_epoch;
  int r_got [64];
  int wr_seen [64];

  function automatic int count_miss();
    int m = 0;
    for (int k = 0; k < 64; k++) if (wr_seen[k] != 1) m++;
    return m;
  endfunction

  task automatic model_reset();
    exp_epoch = 1'b0;
    for (int k = 0; k < 64; k++) tbl_model[k] = 1;
  endtask

  task automatic write_table(input int a, input int d);
    @(negedge clock);
    qt_wr_en = 1'b1; qt_wr_addr = 6'(a); qt_wr_data = 8'(d);
    @(negedge clock);
    qt_wr_en = 1'b0;
    tbl_model[a] = (d == 0) ? 1 : d;
  endtask

  task automatic run_block(input int stop_at, input bit start_noise, input bit tbl_noise,
                           input bit sw_en, input int sw_addr, input int sw_data);
    int rel;
    int nidx;
    bit fin;
    @(negedge clock);
    start = 1'b1;
    if (sw_en) begin
      qt_wr_en = 1'b1; qt_wr_addr = 6'(sw_addr); qt_wr_data = 8'(sw_data);
      tbl_model[sw_addr] = (sw_data == 0) ? 1 : sw_data;
    end
    for (int k = 0; k < 64; k++) begin
      exp_q[k] = int'(coef_mem[k]) / tbl_model[k];
      wr_seen[k] = 0;
      r_got[k] = -99999;
    end
    exp_epoch = ~exp_epoch;
    r_done_rel = -1; r_done_cnt = 0; r_wr_cnt = 0; r_bad_wr = 0; r_fv = -1; r_lv = -1;
    r_vcnt = 0; r_fw = -1; r_lw = -1; r_bf = -1; r_bl = -1; r_bcnt = 0; r_tag_err = 0;
    r_epoch = 1'bx;
    rel = 0; nidx = 0; fin = 1'b0;
    while (!fin && rel < 400) begin
      @(negedge clock);
      rel++;
      start      = start_noise && (rel == 10 || rel == 40);
      qt_wr_en   = tbl_noise && (rel % 7 == 3) && (rel < 75);
      qt_wr_addr = 6'($urandom);
      qt_wr_data = 8'($urandom_range(2, 255));
      if (busy) begin
        if (r_bf < 0) r_bf = rel;
        r_bl = rel; r_bcnt++;
      end
      if (dif.div_input_valid === 1'b1) begin
        if (r_fv < 0) r_fv = rel;
        r_lv = rel; r_vcnt++;
        if (dif.div_tag[7] !== 1'b1 || dif.div_tag[5:0] !== 6'(nidx)) r_tag_err++;
        if (nidx == 0) r_epoch = dif.div_tag[6];
        nidx++;
      end
      if (out_wr_en === 1'b1) begin
        if (r_fw < 0) r_fw = rel;
        r_lw = rel; r_wr_cnt++;
        wr_seen[out_wr_addr]++;
        r_got[out_wr_addr] = int'(out_wr_data);
        if (int'(out_wr_data) != exp_q[out_wr_addr]) r_bad_wr++;
      end
      if (done === 1'b1) begin
        r_done_cnt++; r_done_rel = rel; fin = 1'b1;
      end
      if (rel == stop_at) fin = 1'b1;
    end
    start = 1'b0;
    qt_wr_en = 1'b0;
  endtask

  task automatic test_reset();
    int wr = 0;
    int bz = 0;
    inject_mode = 2;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_tests++; if (out_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", out_wr_en); end
    n_tests++; if (dif.div_input_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_div_valid: got %b want 0", dif.div_input_valid); end
    n_tests++; if (coef_rd_addr !== 6'd0) begin
      n_fail++; $display("FAIL reset_rd_addr: got %0d want 0", coef_rd_addr); end
    reset = 1'b0;
    model_reset();
    repeat (12) begin
      @(negedge clock);
      if (out_wr_en !== 1'b0) wr++;
      if (busy !== 1'b0 || done !== 1'b0) bz++;
    end
    n_tests++; if (wr != 0) begin n_fail++; $display("FAIL idle_garbage_writes: got %0d want 0", wr); end
    n_tests++; if (bz != 0) begin n_fail++; $display("FAIL idle_busy_cycles: got %0d want 0", bz); end
    inject_mode = 0;
  endtask

  task automatic test_table_default();
    for (int k = 0; k < 64; k++) coef_mem[k] = 16'(k * 3 - 96);
    run_block(0, 1'b0, 1'b0, 1'b0, 0, 0);
    n_tests++; if (r_done_rel != D + 67) begin
      n_fail++; $display("FAIL default_done_cycle: got %0d want %0d", r_done_rel, D + 67); end
    n_tests++; if (r_bf != 1 || r_bl != D + 66 || r_bcnt != D + 66) begin
      n_fail++; $display("FAIL default_busy_window: got %0d..%0d (%0d) want 1..%0d",
                         r_bf, r_bl, r_bcnt, D + 66); end
    n_tests++; if (r_fv != 2 || r_lv != 65 || r_vcnt != 64) begin
      n_fail++; $display("FAIL default_issue_window: got %0d..%0d (%0d) want 2..65 (64)",
                         r_fv, r_lv, r_vcnt); end
    n_tests++; if (r_fw != D + 3 || r_lw != D + 66) begin
      n_fail++; $display("FAIL default_write_window: got %0d..%0d want %0d..%0d",
                         r_fw, r_lw, D + 3, D + 66); end
    n_tests++; if (r_wr_cnt != 64 || r_bad_wr != 0 || count_miss() != 0) begin
      n_fail++; $display("FAIL default_data: got %0d writes %0d bad want 64 writes 0 bad",
                         r_wr_cnt, r_bad_wr); end
    n_tests++; if (r_tag_err != 0 || r_epoch !== exp_epoch) begin
      n_fail++; $display("FAIL default_tags: got %0d tag errors epoch %b want 0 epoch %b",
                         r_tag_err, r_epoch, exp_epoch); end
    @(negedge clock);
    n_tests++; if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL default_done_pulse: got done %b busy %b want 0 0", done, busy); end
  endtask

  task automatic test_table_load();
    for (int i = 0; i < 64; i++) write_table(i, i + 1);
    write_table(5, 0);
    for (int k = 0; k < 64; k++) coef_mem[k] = 16'sd1000;
    run_block(0, 1'b0, 1'b0, 1'b0, 0, 0);
    n_tests++; if (r_got[0] != 1000 || r_got[5] != 1000 || r_got[9] != 100 || r_got[63] != 15) begin
      n_fail++; $display("FAIL load_values: got %0d %0d %0d %0d want 1000 1000 100 15",
                         r_got[0], r_got[5], r_got[9], r_got[63]); end
    n_tests++; if (r_wr_cnt != 64 || r_bad_wr != 0 || r_done_cnt != 1) begin
      n_fail++; $display("FAIL load_data: got %0d writes %0d bad %0d done want 64 0 1",
                         r_wr_cnt, r_bad_wr, r_done_cnt); end
  endtask

  task automatic test_negative();
    for (int i = 0; i < 6; i++) write_table(int'($urandom_range(10, 63)), (i == 2) ? 0 : int'($urandom_range(1, 255)));
    for (int k = 0; k < 64; k++) coef_mem[k] = 16'(int'($urandom_range(0, 8000)) - 4000);
    coef_mem[3] = -16'sd300;
    // Table write in the same cycle as start must apply to this block.
    run_block(0, 1'b0, 1'b1, 1'b1, 3, 7);
    n_tests++; if (r_got[3] != -42) begin
      n_fail++; $display("FAIL negative_quotient: got %0d want -42", r_got[3]); end
    n_tests++; if (r_wr_cnt != 64 || r_bad_wr != 0 || r_done_cnt != 1) begin
      n_fail++; $display("FAIL negative_data: got %0d writes %0d bad %0d done want 64 0 1",
                         r_wr_cnt, r_bad_wr, r_done_cnt); end
    for (int k = 0; k < 64; k++) coef_mem[k] = 16'(int'($urandom_range(0, 60000)) - 30000);
    run_block(0, 1'b0, 1'b0, 1'b0, 0, 0);
    n_tests++; if (r_wr_cnt != 64 || r_bad_wr != 0) begin
      n_fail++; $display("FAIL busy_writes_ignored: got %0d writes %0d bad want 64 0",
                         r_wr_cnt, r_bad_wr); end
  endtask

  task automatic test_reset_abort();
    int wr = 0;
    int dn = 0;
    for (int k = 0; k < 64; k++) coef_mem[k] = 16'($urandom);
    run_block(20, 1'b0, 1'b0, 1'b0, 0, 0);
    reset = 1'b1;
    #1;
    n_tests++; if (busy !== 1'b0 || dif.div_input_valid !== 1'b0 || out_wr_en !== 1'b0) begin
      n_fail++; $display("FAIL abort_immediate: got busy %b valid %b wr %b want 0 0 0",
                         busy, dif.div_input_valid, out_wr_en); end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_reset();
    repeat (30) begin
      @(negedge clock);
      if (out_wr_en !== 1'b0) wr++;
      if (done !== 1'b0) dn++;
    end
    n_tests++; if (wr != 0 || dn != 0) begin
      n_fail++; $display("FAIL abort_stale: got %0d writes %0d done want 0 0", wr, dn); end
    for (int k = 0; k < 64; k++) coef_mem[k] = coef_mem[k] ^ 16'h5555;
    run_block(0, 1'b0, 1'b0, 1'b0, 0, 0);
    n_tests++; if (r_wr_cnt != 64 || r_bad_wr != 0 || count_miss() != 0 || r_done_cnt != 1) begin
      n_fail++; $display("FAIL abort_second_block: got %0d writes %0d bad %0d done want 64 0 1",
                         r_wr_cnt, r_bad_wr, r_done_cnt); end
    n_tests++; if (r_done_rel != D + 67) begin
      n_fail++; $display("FAIL abort_done_cycle: got %0d want %0d", r_done_rel, D + 67); end
  endtask

  task automatic test_protocol();
    perm_mode = 1'b1;
    inject_mode = 1;
    for (int k = 0; k < 64; k++) coef_mem[k] = 16'($urandom);
    for (int i = 0; i < 4; i++) write_table(int'($urandom_range(0, 63)), int'($urandom_range(0, 255)));
    run_block(0, 1'b1, 1'b0, 1'b0, 0, 0);
    perm_mode = 1'b0;
    inject_mode = 0;
    n_tests++; if (r_wr_cnt != 64 || count_miss() != 0 || r_bad_wr != 0) begin
      n_fail++; $display("FAIL protocol_writes: got %0d writes %0d missing %0d bad want 64 0 0",
                         r_wr_cnt, count_miss(), r_bad_wr); end
    n_tests++; if (r_done_cnt != 1 || r_vcnt != 64 || r_fv != 2 || r_lv != 65) begin
      n_fail++; $display("FAIL protocol_start_ignored: got done %0d issues %0d (%0d..%0d) want 1 64 (2..65)",
                         r_done_cnt, r_vcnt, r_fv, r_lv); end
  endtask

  task automatic test_back_to_back();
    logic e1;
    for (int k = 0; k < 64; k++) coef_mem[k] = 16'($urandom);
    run_block(0, 1'b0, 1'b0, 1'b0, 0, 0);
    e1 = r_epoch;
    n_tests++; if (r_done_rel != D + 67 || r_bad_wr != 0) begin
      n_fail++; $display("FAIL b2b_first: got done %0d bad %0d want %0d 0", r_done_rel, r_bad_wr, D + 67); end
    for (int k = 0; k < 64; k++) coef_mem[k] = 16'($urandom);
    run_block(0, 1'b0, 1'b0, 1'b0, 0, 0);
    n_tests++; if (r_done_rel != D + 67 || r_wr_cnt != 64 || r_bad_wr != 0) begin
      n_fail++; $display("FAIL b2b_second: got done %0d writes %0d bad %0d want %0d 64 0",
                         r_done_rel, r_wr_cnt, r_bad_wr, D + 67); end
    n_tests++; if (r_epoch === e1 || r_epoch !== exp_epoch) begin
      n_fail++; $display("FAIL b2b_epoch: got %b after %b want %b", r_epoch, e1, exp_epoch); end
  endtask

  initial begin
    for (int k = 0; k < 64; k++) coef_mem[k] = '0;
    model_reset();
    test_reset();
    test_table_default();
    test_table_load();
    test_negative();
    test_reset_abort();
    test_protocol();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
